fp_mult_arb: RTL and testbench

FP_MULT_ARB -- requirements
Module: fp_mult_arb

---
 rtl/fp_mult_pkg.sv | 17 +
 rtl/fp_mult_arb_mult_top.sv | 60 ++++++
 rtl/fp_mult_arb.sv | 96 +++++++++
 tb/tb_fp_mult_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared FP8 (1 sign, 3 exponent, 4 mantissa, bias 3) types and constants
// for the fp_mult_arb block and its multiplier.
package fp_mult_pkg;

    typedef logic [7:0] fp8_t;

    localparam int   EXP_W    = 3;
    localparam int   MANT_W   = 4;
    localparam int   BIAS     = 3;
    localparam fp8_t FP8_ZERO = 8'h00;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

endpackage

// File: rtl/fp_mult_arb_mult_top.sv
// mult_top: combinational FP8 multiplier. Rounds toward zero, saturates to the
// largest finite magnitude, flushes results below the smallest denormal to +0.
module mult_top
    import fp_mult_pkg::*;
(
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] res
);

    // Product scaled so one LSB equals the smallest denormal step, 2^-6.
    localparam int SHIFT = BIAS + MANT_W + 1;

    logic              sign;
    logic [MANT_W:0]   sig_a;
    logic [MANT_W:0]   sig_b;
    logic [EXP_W:0]    exp_a;
    logic [EXP_W:0]    exp_b;
    logic [EXP_W:0]    exp_sum;
    logic [2*MANT_W+1:0] prod;
    logic [15:0]       q;
    logic [3:0]        lead;

    always_comb begin
        sign = in_a[7] ^ in_b[7];
        if (in_a[MANT_W +: EXP_W] == '0) begin
            sig_a = {1'b0, in_a[MANT_W-1:0]};
            exp_a = 4'd1;
        end else begin
            sig_a = {1'b1, in_a[MANT_W-1:0]};
            exp_a = {1'b0, in_a[MANT_W +: EXP_W]};
        end
        if (in_b[MANT_W +: EXP_W] == '0) begin
            sig_b = {1'b0, in_b[MANT_W-1:0]};
            exp_b = 4'd1;
        end else begin
            sig_b = {1'b1, in_b[MANT_W-1:0]};
            exp_b = {1'b0, in_b[MANT_W +: EXP_W]};
        end
        prod    = sig_a * sig_b;
        exp_sum = exp_a + exp_b;
        q       = 16'(({14'd0, prod} << exp_sum) >> SHIFT);

        lead = '0;
        for (int i = 0; i < 16; i++) begin
            if (q[i]) lead = 4'(i);
        end

        if (q == '0) begin
            res = FP8_ZERO;
        end else if (q[15:4] == '0) begin
            res = {sign, 3'b000, q[3:0]};
        end else if (lead > 4'd10) begin
            res = {sign, 7'h7F};
        end else begin
            res = {sign, 3'(lead - 4'd3), 4'(q >> (lead - 4'd4))};
        end
    end

endmodule

// File: rtl/fp_mult_arb.sv
// fp_mult_arb: round-robin arbiter feeding one FP8 multiplier into a one-deep
// result slot. Define FP_MULT_ARB_STATS_EN to add the op_count accept counter.
module fp_mult_arb
    import fp_mult_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*8-1:0]  req_a,
    input  logic [N_REQ*8-1:0]  req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [7:0]          resp_data,
    output logic [ID_W-1:0]     resp_id
`ifdef FP_MULT_ARB_STATS_EN
    ,
    output logic [15:0]         op_count
`endif
);

    // Handshake: a requester's pair transfers on a rising edge where req_valid[i]
    // and req_ready[i] are both high; the result transfers where resp_valid and
    // resp_ready are both high. A dropped req_valid leaves no trace.
    slot_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] winner;
    logic [ID_W:0]   cand;
    logic           found;
    logic           adv;
    logic           accept;
    logic [7:0]     win_a;
    logic [7:0]     win_b;
    logic [7:0]     product;

    // Scan downward so the last hit is the first requester at or after ptr.
    always_comb begin
        adv    = (state == SLOT_EMPTY) || resp_ready;
        found  = 1'b0;
        winner = ptr;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
            if (req_valid[cand[ID_W-1:0]]) begin
                winner = cand[ID_W-1:0];
                found  = 1'b1;
            end
        end
        accept    = adv && found && !rst;
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
        ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        win_a    = req_a[{winner, 3'b000} +: 8];
        win_b    = req_b[{winner, 3'b000} +: 8];
    end

    mult_top u_mult (
        .in_a (win_a),
        .in_b (win_b),
        .res  (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SLOT_EMPTY;
            resp_data <= FP8_ZERO;
            resp_id   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            state     <= SLOT_FULL;
            resp_data <= product;
            resp_id   <= winner;
            ptr       <= ptr_next;
        end else if (resp_ready) begin
            state     <= SLOT_EMPTY;
        end
    end

    assign resp_valid = (state == SLOT_FULL);

`ifdef FP_MULT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (accept && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_arb.sv
// tb_fp_mult_arb: directed and random stimulus for fp_mult_arb, checked against
// a real-valued FP8 reference and a round-robin model. Honors FP_MULT_ARB_STATS_EN.
module tb_fp_mult_arb;

    localparam int N_REQ = 4;
    localparam int ID_W  = $clog2(N_REQ);

    logic                clk        = 1'b0;
    logic                rst        = 1'b1;
    logic [N_REQ-1:0]    req_valid  = '0;
    logic [N_REQ*8-1:0]  req_a      = '0;
    logic [N_REQ*8-1:0]  req_b      = '0;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [7:0]          resp_data;
    logic [ID_W-1:0]     resp_id;
`ifdef FP_MULT_ARB_STATS_EN
    logic [15:0]         op_count;
`endif

    int checks = 0;
    int errors = 0;

    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_data  = 8'h00;
    int          m_id    = 0;
    int          m_cnt   = 0;
    logic [7:0]  exp_q[$];
    logic [N_REQ-1:0] last_ready;

    fp_mult_arb #(.N_REQ(N_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef FP_MULT_ARB_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Magnitude of an FP8 code as a real number.
    function automatic real fp8_mag(input logic [7:0] x);
        int  e;
        real v;
        e = int'(x[6:4]);
        if (e == 0) begin
            v = real'(x[3:0]) / 64.0;
        end else begin
            v = 1.0 + real'(x[3:0]) / 16.0;
            for (int i = 0; i < e; i++) v = v * 2.0;
            v = v / 8.0;
        end
        return v;
    endfunction

    // Largest representable magnitude not above the exact product; zero is +0.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        real        p;
        logic [6:0] best;
        p    = fp8_mag(a) * fp8_mag(b);
        best = '0;
        for (int c = 0; c < 128; c++) begin
            if (fp8_mag(8'(c)) <= p) best = 7'(c);
        end
        return (best == '0) ? 8'h00 : {a[7] ^ b[7], best};
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        logic [N_REQ*8-1:0] mask;
        mask  = (N_REQ*8)'(8'hFF) << (i * 8);
        req_a = (req_a & ~mask) | ((N_REQ*8)'(a) << (i * 8));
        req_b = (req_b & ~mask) | ((N_REQ*8)'(b) << (i * 8));
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_REQ; i++) set_ops(i, 8'($urandom), 8'($urandom));
    endtask

    // One clock: drive, check combinational ready, clock, update model, check outputs.
    task automatic step(input logic [N_REQ-1:0] rv, input logic rr, input logic do_rst,
                        input string tag);
        logic [N_REQ-1:0] exp_ready;
        logic [7:0]       a;
        logic [7:0]       b;
        int               win;
        req_valid  = rv;
        resp_ready = rr;
        rst        = do_rst;
        #1;
        win = -1;
        if (!do_rst && (!m_valid || rr)) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (win < 0 && ((rv >> ((m_ptr + k) % N_REQ)) & 1) != 0)
                    win = (m_ptr + k) % N_REQ;
            end
        end
        exp_ready = '0;
        a = 8'h00;
        b = 8'h00;
        if (win >= 0) begin
            exp_ready = N_REQ'(1) << win;
            a = 8'(req_a >> (win * 8));
            b = 8'(req_b >> (win * 8));
        end
        last_ready = req_ready;
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        if (!do_rst && m_valid && rr)
            check({tag, ".take"}, 32'(resp_data), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        if (do_rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_id    = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            exp_q.delete();
        end else if (win >= 0) begin
            m_data  = ref_mul(a, b);
            exp_q.push_back(m_data);
            m_valid = 1'b1;
            m_id    = win;
            m_ptr   = (win + 1) % N_REQ;
            if (m_cnt < 65535) m_cnt++;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        check({tag, ".valid"}, 32'(resp_valid), 32'(m_valid));
        check({tag, ".data"},  32'(resp_data),  32'(m_data));
        check({tag, ".id"},    32'(resp_id),    32'(m_id));
        check({tag, ".ptr"},   32'(dut.ptr),    32'(m_ptr));
`ifdef FP_MULT_ARB_STATS_EN
        check({tag, ".cnt"},   32'(op_count),   32'(m_cnt));
`endif
    endtask

    logic [N_REQ-1:0] rdy_tab[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int               id_tab[5]  = '{0, 1, 2, 3, 0};
    logic [7:0]       bnd_a[6]   = '{8'h7F, 8'hFF, 8'h01, 8'h08, 8'h80, 8'h3F};
    logic [7:0]       bnd_b[6]   = '{8'h7F, 8'h7F, 8'h01, 8'h40, 8'h45, 8'h3F};
    logic [7:0]       bnd_e[6]   = '{8'h7F, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h4E};

    initial begin
        logic [7:0]      held_data;
        logic [ID_W-1:0] held_id;

        // Reset state.
        step('0, 1'b0, 1'b1, "rst0");
        step(4'b1111, 1'b1, 1'b1, "rst1");

        // Round-robin rotation with every requester asserting.
        rand_ops();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1, 1'b0, "rr");
            check("rr.ready_lit", 32'(last_ready), 32'(rdy_tab[i]));
            check("rr.id_lit", 32'(resp_id), 32'(id_tab[i]));
        end

        // Sign handling and pointer order from ptr=0.
        step('0, 1'b1, 1'b1, "sg.rst");
        set_ops(2, 8'h30, 8'h40);
        set_ops(0, 8'hB0, 8'h40);
        step(4'b0101, 1'b1, 1'b0, "sg0");
        check("sg0.lit", 32'({resp_data, 6'(resp_id)}), 32'({8'hC0, 6'd0}));
        step(4'b0101, 1'b1, 1'b0, "sg1");
        check("sg1.lit", 32'({resp_data, 6'(resp_id)}), 32'({8'h40, 6'd2}));

        // Zero operand.
        set_ops(1, 8'h00, 8'h45);
        step(4'b0010, 1'b1, 1'b0, "zero");
        check("zero.lit", 32'({resp_data, 6'(resp_id)}), 32'({8'h00, 6'd1}));

        // Backpressure: slot full, consumer stalled for five cycles.
        held_data = resp_data;
        held_id   = resp_id;
        rand_ops();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0, "stall");
            check("stall.ready_lit", 32'(last_ready), 32'(0));
            check("stall.hold", 32'({resp_data, 6'(resp_id)}), 32'({held_data, 6'(held_id)}));
        end
        step(4'b1111, 1'b1, 1'b0, "reload");
        check("reload.accept", 32'(last_ready != '0), 32'(1));
        check("reload.full", 32'(resp_valid), 32'(1));

        // Boundary operands: saturation, sign, underflow, denormal.
        for (int i = 0; i < 6; i++) begin
            set_ops(i % N_REQ, bnd_a[i], bnd_b[i]);
            step(N_REQ'(1) << (i % N_REQ), 1'b1, 1'b0, "bnd");
            check("bnd.lit", 32'(resp_data), 32'(bnd_e[i]));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            step(N_REQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0, "rnd");
        end

        // Reset while full with requests pending.
        step('0, 1'b1, 1'b1, "rf.pre");
        rand_ops();
        step(4'b0010, 1'b1, 1'b0, "rf.load");
        step(4'b1111, 1'b0, 1'b0, "rf.stall");
        step(4'b1111, 1'b0, 1'b1, "rf.rst0");
        step(4'b1111, 1'b0, 1'b1, "rf.rst1");
        check("rf.ptr_lit", 32'(dut.ptr), 32'(0));
        step(4'b1111, 1'b1, 1'b0, "rf.first");
        check("rf.first_lit", 32'(last_ready), 32'(4'b0001));
        check("rf.id_lit", 32'(resp_id), 32'(0));

`ifdef FP_MULT_ARB_STATS_EN
        // Accept counter saturation and clear.
        step('0, 1'b1, 1'b1, "st.rst");
        req_valid  = '1;
        resp_ready = 1'b1;
        rst        = 1'b0;
        repeat (65537) @(posedge clk);
        #1;
        check("st.sat", 32'(op_count), 32'(16'hFFFF));
        @(posedge clk);
        #1;
        check("st.hold", 32'(op_count), 32'(16'hFFFF));
        step('0, 1'b0, 1'b1, "st.clr");
        check("st.zero", 32'(op_count), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
